// File: rtl/jtdd_snd_bridge.sv
// Main-to-sound CPU byte bridge: a 4-entry FIFO when JTDD_SNDFIFO_EN is defined,
// otherwise a single-entry latch where an unread byte is overwritten and flagged.
module jtdd_snd_bridge (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       main_wr,
    input  logic [7:0] main_din,
    input  logic       sres_b,
    input  logic       snd_rd,
    output logic [7:0] snd_dout,
    output logic       snd_irq_n,
    output logic       pending,
    output logic [2:0] count,
    output logic       overflow
);

`ifdef JTDD_SNDFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic [7:0] dout_q, dout_d;
    logic       irq_n_q;
    logic       armed_q;

    logic wr_en, rd_en, do_wr, do_rd, full, lost, grow;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        // Strobes are ignored on the clk edge that releases reset.
        wr_en = main_wr & armed_q;
        rd_en = snd_rd & armed_q;
        do_rd = rd_en & (count_q != 3'd0);
        full  = (count_q == 3'(DEPTH));
        lost  = wr_en & full & ~do_rd;
`ifdef JTDD_SNDFIFO_EN
        do_wr = wr_en & ~lost;
        grow  = do_wr;
`else
        // The latch overwrites its only entry; wr_ptr and rd_ptr both stay at 0.
        do_wr = wr_en;
        grow  = do_wr & ~lost;
`endif
        rd_ptr_d = do_rd ? ptr_next(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_wr ? ptr_next(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + 3'(grow) - 3'(do_rd);
        ovf_d    = ovf_q | lost;
        dout_d   = dout_q;
        // The new head is the incoming byte when it lands where rd_ptr will point.
        if (count_d != 3'd0) begin
            dout_d = (do_wr && (wr_ptr_q == rd_ptr_d)) ? main_din : mem_q[rd_ptr_d];
        end
        if (!sres_b) begin
            do_wr    = 1'b0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
            ovf_d    = 1'b0;
            dout_d   = dout_q;
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            dout_q   <= 8'h00;
            irq_n_q  <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
            irq_n_q  <= (count_d == 3'd0);
            armed_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= main_din;
    end

    assign snd_dout  = dout_q;
    assign snd_irq_n = irq_n_q;
    assign pending   = ~irq_n_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule
